// File: rtl/pcie_perst_seq_pkg.sv
// Shared constants and state encoding for the drive-bay PERST# sequencer.
// Replaces the old baseboard_define.v include.
package pcie_perst_seq_pkg;

  // 100 ms at the 2 MHz CPLD system clock; fits the default 18-bit counter
  localparam int TIME_100MS = 200000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_PWR = 2'd1,
    ST_RUN      = 2'd2,
    ST_SW_RST   = 2'd3
  } chan_state_e;

endpackage

// File: rtl/pcie_perst_seq_if.sv
// Per-drive control and status bundle between the BMC/CPLD fabric and the
// PERST# sequencer.
interface pcie_perst_seq_if #(
  parameter int NUM_DRV = 24
);
  logic [NUM_DRV-1:0] DRV_PWROK;
  logic [NUM_DRV-1:0] DRV_EN;
  logic [NUM_DRV-1:0] DUAL_PORT;
  logic [NUM_DRV-1:0] SW_RST_REQ;
  logic [NUM_DRV-1:0] FAULT_CLR;
  logic [NUM_DRV-1:0] PE_RST_A_L;
  logic [NUM_DRV-1:0] PE_RST_B_L;
  logic [NUM_DRV-1:0] DRV_LINK_RDY;
  logic [NUM_DRV-1:0] PWR_FAULT;

  modport master (
    output DRV_PWROK, DRV_EN, DUAL_PORT, SW_RST_REQ, FAULT_CLR,
    input  PE_RST_A_L, PE_RST_B_L, DRV_LINK_RDY, PWR_FAULT
  );

  modport slave (
    input  DRV_PWROK, DRV_EN, DUAL_PORT, SW_RST_REQ, FAULT_CLR,
    output PE_RST_A_L, PE_RST_B_L, DRV_LINK_RDY, PWR_FAULT
  );
endinterface

// File: rtl/pcie_perst_seq_chan.sv
// One drive channel: PWROK synchroniser and debounce, power/warm-reset FSM,
// delay counter and sticky power-fault flag.
module pcie_perst_seq_chan
  import pcie_perst_seq_pkg::*;
#(
  parameter int CNT_W     = 18,
  parameter int T_PWR_DLY = TIME_100MS,
  parameter int T_DEB     = 16,
  parameter int T_SWRST   = 2000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwrok_raw,
  input  logic drv_en,
  input  logic sw_rst_req,
  input  logic fault_clr,
  output logic run_o,
  output logic pe_rst_a_l_o,
  output logic pwr_fault_o
);

  localparam int DEB_W = $clog2(T_DEB + 1);

  logic             sync1_q, sync2_q;
  logic             filt_q, filt_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             perst_q, perst_d;
  logic             fault_q, fault_d;
  logic             fault_set;

  // Filtered value only moves after T_DEB consecutive disagreeing samples
  always_comb begin
    filt_d    = filt_q;
    deb_cnt_d = '0;
    if (sync2_q != filt_q) begin
      if (deb_cnt_q == DEB_W'(T_DEB - 1)) begin
        filt_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!filt_q || !drv_en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_WAIT_PWR;
          cnt_d   = '0;
        end
        ST_WAIT_PWR: begin
          if (sw_rst_req) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_W'(T_PWR_DLY - 1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (sw_rst_req) begin
            state_d = ST_SW_RST;
            cnt_d   = '0;
          end
        end
        ST_SW_RST: begin
          if (sw_rst_req) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_W'(T_SWRST - 1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // A fault is only a power loss seen while the link was (or is being) up
  always_comb begin
    perst_d   = (state_q == ST_RUN);
    fault_set = !filt_q && ((state_q == ST_RUN) || (state_q == ST_SW_RST));
    fault_d   = fault_q;
    if (fault_set) begin
      fault_d = 1'b1;
    end else if (fault_clr) begin
      fault_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      filt_q    <= 1'b0;
      deb_cnt_q <= '0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      perst_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      sync1_q   <= pwrok_raw;
      sync2_q   <= sync1_q;
      filt_q    <= filt_d;
      deb_cnt_q <= deb_cnt_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      perst_q   <= perst_d;
      fault_q   <= fault_d;
    end
  end

  assign run_o        = (state_q == ST_RUN);
  assign pe_rst_a_l_o = perst_q;
  assign pwr_fault_o  = fault_q;

endmodule

// File: rtl/pcie_perst_seq.sv
// Drive-bay PCIe reset sequencer: one independent channel per drive plus the
// registered port-B select.
module pcie_perst_seq
  import pcie_perst_seq_pkg::*;
#(
  parameter int NUM_DRV   = 24,
  parameter int CNT_W     = 18,
  parameter int T_PWR_DLY = TIME_100MS,
  parameter int T_DEB     = 16,
  parameter int T_SWRST   = 2000
) (
  input logic                SYSCLK,
  input logic                RESET_N,
  pcie_perst_seq_if.slave    bus
);

  logic [NUM_DRV-1:0] run_vec;
  logic [NUM_DRV-1:0] pe_a_vec;
  logic [NUM_DRV-1:0] fault_vec;
  logic [NUM_DRV-1:0] pe_b_q, pe_b_d;

  for (genvar i = 0; i < NUM_DRV; i++) begin : g_chan
    pcie_perst_seq_chan #(
      .CNT_W    (CNT_W),
      .T_PWR_DLY(T_PWR_DLY),
      .T_DEB    (T_DEB),
      .T_SWRST  (T_SWRST)
    ) u_chan (
      .clk         (SYSCLK),
      .rst_n       (RESET_N),
      .pwrok_raw   (bus.DRV_PWROK[i]),
      .drv_en      (bus.DRV_EN[i]),
      .sw_rst_req  (bus.SW_RST_REQ[i]),
      .fault_clr   (bus.FAULT_CLR[i]),
      .run_o       (run_vec[i]),
      .pe_rst_a_l_o(pe_a_vec[i]),
      .pwr_fault_o (fault_vec[i])
    );
  end

  // Port B registers from the same state as port A, so it tracks A exactly
  // while DUAL_PORT is steady
  always_comb begin
    pe_b_d = run_vec & bus.DUAL_PORT;
  end

  always_ff @(posedge SYSCLK) begin
    if (!RESET_N) begin
      pe_b_q <= '0;
    end else begin
      pe_b_q <= pe_b_d;
    end
  end

  assign bus.PE_RST_A_L   = pe_a_vec;
  assign bus.PE_RST_B_L   = pe_b_q;
  assign bus.DRV_LINK_RDY = pe_a_vec;
  assign bus.PWR_FAULT    = fault_vec;

endmodule
